stage4_enfast_ns: RTL and testbench

// - FAST encoder stage 4 (NS template): inverse of the stage-4 defast path. Takes decoded 280-bit messages
//   {PID,MC,MT,pad,payload}, applies the copy operator to PID/MC/MT against its own dictionary, and emits
//   the 344-bit fast message {pmap, present fields, payload}. 2-stage valid/ready pipeline feeding the

---
 rtl/stage4_enfast_ns.sv | 182 ++++++++++++++++++
 tb/tb_stage4_enfast_ns.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/stage4_enfast_ns.sv
// ---------------------------------------------------------------------------
// stage4_enfast_ns : FAST encoder stage 4 (NS template)
// Applies the copy operator to PID/MC/MT against a local dictionary and packs
// the present fields plus payload into a 344-bit fast message behind a
// presence map. Two-stage valid/ready pipeline (S1 = copy decision,
// S2 = packed output register).
//
// Ports
//   clk, rst_n            clock, synchronous active-low reset
//   in_valid/in_ready     decoded message handshake
//   in_message[279:0]     {PID,MC,MT,pad,payload,unused}
//   dict_clr              template reset of the PID/MC/MT dictionary
//   out_valid/out_ready   fast message handshake
//   out_fast[343:0]       {pmap[15:0], fields+payload area[327:0]}
//   out_len[3:0]          encoded length in bytes (10..13)
//   stat_msgs/stat_copies emit and elided-field counters
//
// Build option: define STAGE4_ENFAST_STATS_EN to build the statistics
// counters; otherwise stat_msgs/stat_copies are tied to zero.
// ---------------------------------------------------------------------------
module stage4_enfast_ns (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         in_valid,
   output logic         in_ready,
   input  logic [279:0] in_message,
   input  logic         dict_clr,
   output logic         out_valid,
   input  logic         out_ready,
   output logic [343:0] out_fast,
   output logic [3:0]   out_len,
   output logic [31:0]  stat_msgs,
   output logic [31:0]  stat_copies
);

   localparam int unsigned MSG_W   = 280;
   localparam int unsigned FAST_W  = 344;
   localparam int unsigned FIELD_W = 8;
   localparam int unsigned PAY_W   = 64;
   localparam int unsigned AREA_W  = 328;
   localparam int unsigned LEN_W   = 4;
   localparam int unsigned STAT_W  = 32;

   // Input field extraction
   logic [FIELD_W-1:0] in_pid, in_mc, in_mt;
   logic [PAY_W-1:0]   in_pay;
   logic               unused_bits;

   assign in_pid      = in_message[MSG_W-1   -: FIELD_W];
   assign in_mc       = in_message[MSG_W-9   -: FIELD_W];
   assign in_mt       = in_message[MSG_W-17  -: FIELD_W];
   assign in_pay      = in_message[MSG_W-33  -: PAY_W];
   assign unused_bits = ^{in_message[255:248], in_message[183:0]};

   // State
   logic               ready_en_q;
   logic               s1_valid_q, s1_valid_d;
   logic [FIELD_W-1:0] s1_pid_q, s1_mc_q, s1_mt_q;
   logic [2:0]         s1_copy_q, s1_copy_d;      // {PID, MC, MT}
   logic [PAY_W-1:0]   s1_pay_q;
   logic               out_valid_q, out_valid_d;
   logic [FAST_W-1:0]  out_fast_q;
   logic [LEN_W-1:0]   out_len_q;
   logic [FIELD_W-1:0] dict_pid_q, dict_mc_q, dict_mt_q;
   logic [2:0]         def_q, def_d, def_eff;

   logic accept, s2_load;

   // Handshake: S1 frees up when it is empty or moving into S2 this cycle
   always_comb begin
      s2_load    = s1_valid_q & (~out_valid_q | out_ready);
      in_ready   = ready_en_q & (~s1_valid_q | ~out_valid_q | out_ready);
      accept     = in_valid & in_ready;
      s1_valid_d = accept | (s1_valid_q & ~s2_load);
      out_valid_d = s2_load | (out_valid_q & ~out_ready);
   end

   // Copy decision; a coincident dict_clr makes every entry undefined first
   always_comb begin
      def_eff   = dict_clr ? 3'b000 : def_q;
      s1_copy_d = def_eff & {in_pid == dict_pid_q, in_mc == dict_mc_q, in_mt == dict_mt_q};
      def_d     = def_q;
      if (accept)        def_d = 3'b111;
      else if (dict_clr) def_d = 3'b000;
   end

   // Encoder: present fields from the top of the area, payload right after
   logic [AREA_W-1:0] enc_area;
   logic [8:0]        enc_pos;
   logic [1:0]        enc_present;
   logic [FAST_W-1:0] enc_fast;
   logic [LEN_W-1:0]  enc_len;

   always_comb begin
      enc_area    = '0;
      enc_pos     = 9'(AREA_W - 1);
      enc_present = 2'd0;
      if (!s1_copy_q[2]) begin
         enc_area[enc_pos -: FIELD_W] = s1_pid_q;
         enc_pos     = enc_pos - 9'd8;
         enc_present = enc_present + 2'd1;
      end
      if (!s1_copy_q[1]) begin
         enc_area[enc_pos -: FIELD_W] = s1_mc_q;
         enc_pos     = enc_pos - 9'd8;
         enc_present = enc_present + 2'd1;
      end
      if (!s1_copy_q[0]) begin
         enc_area[enc_pos -: FIELD_W] = s1_mt_q;
         enc_pos     = enc_pos - 9'd8;
         enc_present = enc_present + 2'd1;
      end
      enc_area[enc_pos -: PAY_W] = s1_pay_q;
      enc_fast = {1'b1, s1_copy_q, 12'h000, enc_area};
      enc_len  = 4'd10 + {2'b00, enc_present};
   end

   // Pipeline and dictionary registers
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         ready_en_q  <= 1'b0;
         s1_valid_q  <= 1'b0;
         s1_pid_q    <= '0;
         s1_mc_q     <= '0;
         s1_mt_q     <= '0;
         s1_copy_q   <= '0;
         s1_pay_q    <= '0;
         out_valid_q <= 1'b0;
         out_fast_q  <= '0;
         out_len_q   <= '0;
         dict_pid_q  <= '0;
         dict_mc_q   <= '0;
         dict_mt_q   <= '0;
         def_q       <= '0;
      end else begin
         ready_en_q  <= 1'b1;
         s1_valid_q  <= s1_valid_d;
         out_valid_q <= out_valid_d;
         def_q       <= def_d;
         if (accept) begin
            s1_pid_q   <= in_pid;
            s1_mc_q    <= in_mc;
            s1_mt_q    <= in_mt;
            s1_pay_q   <= in_pay;
            s1_copy_q  <= s1_copy_d;
            dict_pid_q <= in_pid;
            dict_mc_q  <= in_mc;
            dict_mt_q  <= in_mt;
         end
         if (s2_load) begin
            out_fast_q <= enc_fast;
            out_len_q  <= enc_len;
         end
      end
   end

   assign out_valid = out_valid_q;
   assign out_fast  = out_fast_q;
   assign out_len   = out_len_q;

`ifdef STAGE4_ENFAST_STATS_EN
   // Emit counters; copy flags of the emitted message live in pmap[14:12]
   logic [STAT_W-1:0] stat_msgs_q, stat_copies_q;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         stat_msgs_q   <= '0;
         stat_copies_q <= '0;
      end else if (out_valid_q && out_ready) begin
         stat_msgs_q   <= stat_msgs_q + 32'd1;
         stat_copies_q <= stat_copies_q + 32'($countones(out_fast_q[342:340]));
      end
   end

   assign stat_msgs   = stat_msgs_q;
   assign stat_copies = stat_copies_q;
`else
   assign stat_msgs   = '0;
   assign stat_copies = '0;
`endif

endmodule

// File: tb/tb_stage4_enfast_ns.sv
// ---------------------------------------------------------------------------
// tb_stage4_enfast_ns : scoreboard bench for stage4_enfast_ns.
// A reference model turns every accepted message into its expected fast
// message (byte list built from the copy rules) and queues it; an independent
// monitor pops and compares whenever the DUT emits.
// ---------------------------------------------------------------------------
module tb_stage4_enfast_ns;

   logic         clk = 1'b0;
   logic         rst_n, in_valid, in_ready, dict_clr, out_valid, out_ready;
   logic [279:0] in_message;
   logic [343:0] out_fast;
   logic [3:0]   out_len;
   logic [31:0]  stat_msgs, stat_copies;

   stage4_enfast_ns dut (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
      .in_message(in_message), .dict_clr(dict_clr), .out_valid(out_valid),
      .out_ready(out_ready), .out_fast(out_fast), .out_len(out_len),
      .stat_msgs(stat_msgs), .stat_copies(stat_copies));

   always #5 clk = ~clk;

   typedef struct {
      logic [343:0] fast;
      logic [3:0]   len;
   } exp_t;

   exp_t exp_q[$];
   int   n_checks = 0;
   int   n_errors = 0;

   task automatic chk(input string name, input logic [343:0] act, input logic [343:0] req);
      n_checks++;
      if (act !== req) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, req);
      end
   endtask

   // Reference model: dictionary of last values plus "defined" flags
   logic [7:0] m_dict[3];
   bit         m_def[3];
   logic [7:0] m_val[3];
   bit         m_cp[3];
   logic [7:0] m_bytes[$];
   logic [63:0] m_pay;
   exp_t       m_e;
   int         m_present;

   always @(negedge clk) begin
      if (!rst_n) begin
         exp_q.delete();
         for (int i = 0; i < 3; i++) begin m_def[i] = 0; m_dict[i] = 8'h00; end
      end else if (in_valid && in_ready) begin
         m_val[0] = in_message[279:272];
         m_val[1] = in_message[271:264];
         m_val[2] = in_message[263:256];
         m_pay    = in_message[247:184];
         m_bytes.delete();
         m_present = 0;
         for (int i = 0; i < 3; i++) begin
            m_cp[i] = m_def[i] && !dict_clr && (m_val[i] == m_dict[i]);
            if (!m_cp[i]) begin m_bytes.push_back(m_val[i]); m_present++; end
         end
         for (int b = 7; b >= 0; b--) m_bytes.push_back(m_pay[8*b +: 8]);
         m_e.fast = '0;
         m_e.fast[343:328] = {1'b1, m_cp[0], m_cp[1], m_cp[2], 12'h000};
         for (int j = 0; j < m_bytes.size(); j++) m_e.fast[327-8*j -: 8] = m_bytes[j];
         m_e.len = 4'(2 + m_present + 8);
         exp_q.push_back(m_e);
         for (int i = 0; i < 3; i++) begin m_dict[i] = m_val[i]; m_def[i] = 1; end
      end else if (dict_clr) begin
         for (int i = 0; i < 3; i++) m_def[i] = 0;
      end
   end

   // Monitor: scoreboard pop, hold-stability under back-pressure, counters
   int           exp_msgs, exp_copies;
   bit           hold_v;
   logic [343:0] hold_fast;
   logic [3:0]   hold_len;
   exp_t         mon_e;

   always @(negedge clk) begin
      if (!rst_n) begin
         hold_v = 0; exp_msgs = 0; exp_copies = 0;
      end else begin
`ifdef STAGE4_ENFAST_STATS_EN
         chk("stat_msgs", 344'(stat_msgs), 344'(32'(exp_msgs)));
         chk("stat_copies", 344'(stat_copies), 344'(32'(exp_copies)));
`else
         chk("stat_msgs_tied", 344'(stat_msgs), 344'(0));
         chk("stat_copies_tied", 344'(stat_copies), 344'(0));
`endif
         if (hold_v) begin
            chk("hold_valid", 344'(out_valid), 344'(1));
            chk("hold_fast", out_fast, hold_fast);
            chk("hold_len", 344'(out_len), 344'(hold_len));
         end
         if (out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
               n_checks++; n_errors++;
               $display("FAIL unexpected_emit: got %0h expected no message", out_fast);
            end else begin
               mon_e = exp_q.pop_front();
               chk("out_fast", out_fast, mon_e.fast);
               chk("out_len", 344'(out_len), 344'(mon_e.len));
               exp_msgs++;
               exp_copies += $countones(mon_e.fast[342:340]);
            end
         end
         hold_v    = out_valid && !out_ready;
         hold_fast = out_fast;
         hold_len  = out_len;
      end
   end

   // Drive one message and wait (bounded) until it is accepted
   task automatic send(input logic [7:0] p, input logic [7:0] mc, input logic [7:0] mt,
                       input logic [63:0] pay, input bit clr);
      bit ok;
      ok = 0;
      in_message = '0;
      in_message[279:272] = p;
      in_message[271:264] = mc;
      in_message[263:256] = mt;
      in_message[255:248] = 8'($urandom);
      in_message[247:184] = pay;
      in_message[31:0]    = $urandom;
      in_valid = 1'b1;
      dict_clr = clr;
      for (int c = 0; c < 200; c++) begin
         @(negedge clk);
         if (in_ready) begin ok = 1; break; end
      end
      if (!ok) begin
         n_checks++; n_errors++;
         $display("FAIL send_timeout: got in_ready=0 expected 1 within 200 cycles");
      end
      @(posedge clk); #1;
      in_valid = 1'b0;
      dict_clr = 1'b0;
   endtask

   task automatic idle(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   logic [63:0] rp;

   initial begin
      rst_n = 1'b0; in_valid = 1'b0; dict_clr = 1'b0; out_ready = 1'b1; in_message = '0;
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;
      chk("rst_in_ready", 344'(in_ready), 344'(0));
      chk("rst_out_valid", 344'(out_valid), 344'(0));
      chk("rst_out_fast", out_fast, 344'(0));
      chk("rst_out_len", 344'(out_len), 344'(0));
      idle(1);
      chk("in_ready_after_rst", 344'(in_ready), 344'(1));

      // First message: all explicit, two-cycle latency
      send(8'h01, 8'h02, 8'h03, 64'h1122334455667788, 0);
      @(negedge clk);
      chk("lat_cycle1_valid", 344'(out_valid), 344'(0));
      @(negedge clk);
      chk("lat_cycle2_valid", 344'(out_valid), 344'(1));
      chk("first_pmap", 344'(out_fast[343:328]), 344'(16'h8000));
      chk("first_fields", 344'(out_fast[327:304]), 344'(24'h010203));
      chk("first_payload", 344'(out_fast[303:240]), 344'(64'h1122334455667788));
      chk("first_len", 344'(out_len), 344'(13));
      @(posedge clk); #1;

      // Copy operator sequence: F000, D000, A000
      send(8'h01, 8'h02, 8'h03, 64'h1122334455667788, 0);
      send(8'h01, 8'h07, 8'h03, 64'hA5A5_0000_FFFF_1234, 0);
      send(8'h09, 8'h07, 8'h05, 64'h0F0E_0D0C_0B0A_0908, 0);
      idle(4);

      // Back-pressure: 4 messages against a stalled output
      #0 out_ready = 1'b0;
      fork
         begin
            for (int i = 0; i < 4; i++)
               send(8'(i), 8'h07, 8'(i & 1), {$urandom, $urandom}, 0);
         end
         begin
            repeat (5) @(negedge clk);
            chk("stall_in_ready", 344'(in_ready), 344'(0));
            chk("stall_out_valid", 344'(out_valid), 344'(1));
            @(posedge clk); #1 out_ready = 1'b1;
         end
      join
      idle(5);

      // dict_clr coincident with accept of a repeated message
      send(8'h44, 8'h55, 8'h66, 64'h0123456789ABCDEF, 0);
      send(8'h44, 8'h55, 8'h66, 64'h0123456789ABCDEF, 1);
      send(8'h44, 8'h55, 8'h66, 64'h0123456789ABCDEF, 0);
      idle(4);

      // Randomised traffic with small field alphabet so copies are frequent
      for (int c = 0; c < 400; c++) begin
         in_valid  = 1'($urandom_range(0, 1));
         out_ready = ($urandom_range(0, 3) != 0);
         dict_clr  = ($urandom_range(0, 15) == 0);
         rp = {$urandom, $urandom};
         in_message = '0;
         in_message[279:272] = 8'($urandom_range(0, 2));
         in_message[271:264] = 8'($urandom_range(0, 1));
         in_message[263:256] = 8'($urandom_range(0, 2));
         in_message[255:248] = 8'($urandom);
         in_message[247:184] = rp;
         in_message[63:0]    = {$urandom, $urandom};
         @(posedge clk); #1;
      end
      in_valid = 1'b0; dict_clr = 1'b0; out_ready = 1'b1;
      idle(6);
      chk("drain_random", 344'(exp_q.size()), 344'(0));

      // Mid-stream reset with both stages occupied
      out_ready = 1'b0;
      send(8'h11, 8'h22, 8'h33, 64'hDEAD_BEEF_0000_0001, 0);
      send(8'h11, 8'h22, 8'h33, 64'hDEAD_BEEF_0000_0002, 0);
      rst_n = 1'b0;
      @(posedge clk); #1 rst_n = 1'b1;
      chk("midrst_out_valid", 344'(out_valid), 344'(0));
      chk("midrst_in_ready", 344'(in_ready), 344'(0));
      out_ready = 1'b1;
      idle(1);
      send(8'h11, 8'h22, 8'h33, 64'hCAFE_F00D_0000_0003, 0);
      send(8'h11, 8'h22, 8'h33, 64'hCAFE_F00D_0000_0004, 0);
      idle(5);
`ifdef STAGE4_ENFAST_STATS_EN
      chk("post_rst_stat_msgs", 344'(stat_msgs), 344'(2));
      chk("post_rst_stat_copies", 344'(stat_copies), 344'(3));
`endif
      chk("final_drain", 344'(exp_q.size()), 344'(0));

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got no finish expected finish before 200000 time units");
      $fatal(1);
   end

endmodule
